sram_test_seq: RTL and testbench

SRAM_TEST_SEQ -- requirements
Module: sram_test_seq

---
 rtl/sram_test_pkg.sv | 22 ++
 rtl/sram_pattern_gen.sv | 28 ++
 rtl/sram_test_seq.sv | 183 ++++++++++++++++++
 tb/tb_sram_test_seq.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_test_pkg.sv
// Shared types for the SRAM test sequencer: FSM states, pattern selects, error counter width.
package sram_test_pkg;

    localparam int unsigned ERR_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StWIssue,
        StWWait,
        StRIssue,
        StRWait,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        PatAddr    = 2'd0,
        PatAddrInv = 2'd1,
        Pat55      = 2'd2,
        PatAa      = 2'd3
    } pat_sel_e;

endpackage

// File: rtl/sram_pattern_gen.sv
// Combinational test-pattern generator shared by the write-data and read-compare paths.
module sram_pattern_gen
    import sram_test_pkg::*;
#(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 8
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  pat_sel_e          sel_i,
    output logic [DATA_W-1:0] data_o
);

    logic [7:0] addr_byte;
    logic [7:0] pat_byte;

    always_comb begin
        addr_byte = 8'(addr_i);
        pat_byte  = '0;
        unique case (sel_i)
            PatAddr:    pat_byte = addr_byte;
            PatAddrInv: pat_byte = ~addr_byte;
            Pat55:      pat_byte = 8'h55;
            PatAa:      pat_byte = 8'hAA;
        endcase
        data_o = DATA_W'(pat_byte);
    end

endmodule

// File: rtl/sram_test_seq.sv
// Write-then-read-back SRAM test sequencer driving a ready/strobe SRAM controller;
// records miscompare count and the first failing address/data.
module sram_test_seq
    import sram_test_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 19,
    parameter int unsigned       DATA_W    = 8,
    parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(19'h7FFFF)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        pattern_sel,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_exp,
    output logic [DATA_W-1:0] first_err_act,
    output logic              mem,
    output logic              rw,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_f2s,
    input  logic              ready,
    input  logic [DATA_W-1:0] data_s2f_r
);

    state_e            state_q, state_d;
    pat_sel_e          sel_q, sel_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              abort_q, abort_d;
    logic              seen_low_q, seen_low_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [ADDR_W-1:0] ferr_addr_q, ferr_addr_d;
    logic [DATA_W-1:0] ferr_exp_q, ferr_exp_d;
    logic [DATA_W-1:0] ferr_act_q, ferr_act_d;

    logic [DATA_W-1:0] pat;
    logic              active;
    logic              abort_now;
    logic              op_done;
    logic              is_last;

    sram_pattern_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_pattern_gen (
        .addr_i (cnt_q),
        .sel_i  (sel_q),
        .data_o (pat)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        abort_d     = abort_q;
        seen_low_d  = seen_low_q;
        err_d       = err_q;
        ferr_addr_d = ferr_addr_q;
        ferr_exp_d  = ferr_exp_q;
        ferr_act_d  = ferr_act_q;

        active    = (state_q != StIdle) && (state_q != StDone);
        abort_now = abort_q || abort;
        // Completion is the first ready=1 after the controller has dropped ready.
        op_done   = ready && seen_low_q;
        is_last   = (cnt_q == LAST_ADDR);

        if (active && abort) begin
            abort_d = 1'b1;
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StWIssue;
                    sel_d       = pat_sel_e'(pattern_sel);
                    cnt_d       = '0;
                    abort_d     = 1'b0;
                    err_d       = '0;
                    ferr_addr_d = '0;
                    ferr_exp_d  = '0;
                    ferr_act_d  = '0;
                end
            end
            StWIssue, StRIssue: begin
                // An accepted command must run to completion even if abort is pending.
                if (ready) begin
                    state_d    = (state_q == StWIssue) ? StWWait : StRWait;
                    seen_low_d = 1'b0;
                end else if (abort_now) begin
                    state_d = StIdle;
                    abort_d = 1'b0;
                end
            end
            StWWait: begin
                if (!ready) begin
                    seen_low_d = 1'b1;
                end else if (op_done) begin
                    if (abort_now) begin
                        state_d = StIdle;
                        abort_d = 1'b0;
                    end else if (is_last) begin
                        state_d = StRIssue;
                        cnt_d   = '0;
                    end else begin
                        state_d = StWIssue;
                        cnt_d   = cnt_q + ADDR_W'(1);
                    end
                end
            end
            StRWait: begin
                if (!ready) begin
                    seen_low_d = 1'b1;
                end else if (op_done) begin
                    if (data_s2f_r != pat) begin
                        if (err_q != '1) begin
                            err_d = err_q + ERR_W'(1);
                        end
                        if (err_q == '0) begin
                            ferr_addr_d = cnt_q;
                            ferr_exp_d  = pat;
                            ferr_act_d  = data_s2f_r;
                        end
                    end
                    if (abort_now) begin
                        state_d = StIdle;
                        abort_d = 1'b0;
                    end else if (is_last) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRIssue;
                        cnt_d   = cnt_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            sel_q       <= PatAddr;
            cnt_q       <= '0;
            abort_q     <= 1'b0;
            seen_low_q  <= 1'b0;
            err_q       <= '0;
            ferr_addr_q <= '0;
            ferr_exp_q  <= '0;
            ferr_act_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            abort_q     <= abort_d;
            seen_low_q  <= seen_low_d;
            err_q       <= err_d;
            ferr_addr_q <= ferr_addr_d;
            ferr_exp_q  <= ferr_exp_d;
            ferr_act_q  <= ferr_act_d;
        end
    end

    always_comb begin
        busy           = (state_q != StIdle) && (state_q != StDone);
        done           = (state_q == StDone);
        pass           = done && (err_q == '0);
        err_count      = err_q;
        first_err_addr = ferr_addr_q;
        first_err_exp  = ferr_exp_q;
        first_err_act  = ferr_act_q;
        mem            = (state_q == StWIssue) || (state_q == StRIssue);
        rw             = (state_q == StRIssue) || (state_q == StRWait);
        addr           = cnt_q;
        // Write data is driven only while a write is outstanding so idle/reset shows zero.
        data_f2s       = ((state_q == StWIssue) || (state_q == StWWait)) ? pat : '0;
    end

endmodule

// File: tb/tb_sram_test_seq.sv
// Bench for sram_test_seq: behavioural 3-cycle controller + 16-word SRAM with fault injection,
// command scoreboard and result checks.
module tb_sram_test_seq;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 8;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic              abort;
    logic [1:0]        pattern_sel;
    logic              busy;
    logic              done;
    logic              pass;
    logic [15:0]       err_count;
    logic [ADDR_W-1:0] first_err_addr;
    logic [DATA_W-1:0] first_err_exp;
    logic [DATA_W-1:0] first_err_act;
    logic              mem;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_f2s;
    logic              ready;
    logic [DATA_W-1:0] data_s2f_r;

    int n_tests = 0;
    int n_fail  = 0;
    int cmd_count = 0;
    int fault_mode = 0;
    cmd_t exp_q[$];

    logic [7:0]        sram [0:15];
    logic [1:0]        bcnt;
    logic              c_rw;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_data;

    sram_test_seq #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .LAST_ADDR (19'd15)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .pattern_sel    (pattern_sel),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .first_err_exp  (first_err_exp),
        .first_err_act  (first_err_act),
        .mem            (mem),
        .rw             (rw),
        .addr           (addr),
        .data_f2s       (data_f2s),
        .ready          (ready),
        .data_s2f_r     (data_s2f_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_pat(input int a, input logic [1:0] sel);
        logic [7:0] ab;
        ab = 8'(a);
        case (sel)
            2'd0:    return ab;
            2'd1:    return ~ab;
            2'd2:    return 8'h55;
            default: return 8'hAA;
        endcase
    endfunction

    function automatic logic [7:0] sram_read(input logic [3:0] a);
        logic [7:0] v;
        v = sram[a];
        if (fault_mode == 1 && a == 4'd5) v[0] = 1'b0;
        if (fault_mode == 2) v = 8'h00;
        return v;
    endfunction

    // Controller model: accept on mem&&ready, ready low two cycles, then ready with result.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready      <= 1'b1;
            bcnt       <= 2'd0;
            data_s2f_r <= '0;
            c_rw       <= 1'b0;
            c_addr     <= '0;
            c_data     <= '0;
        end else if (bcnt == 2'd0) begin
            if (mem && ready) begin
                ready  <= 1'b0;
                bcnt   <= 2'd2;
                c_rw   <= rw;
                c_addr <= addr;
                c_data <= data_f2s;
            end
        end else begin
            bcnt <= bcnt - 2'd1;
            if (bcnt == 2'd1) begin
                ready <= 1'b1;
                if (c_rw) data_s2f_r <= sram_read(c_addr[3:0]);
                else      sram[c_addr[3:0]] <= c_data;
            end
        end
    end

    // Scoreboard: every accepted command must match the next expected one.
    always @(negedge clk) begin
        if (reset_n && mem && ready) begin
            cmd_t e;
            cmd_count++;
            check_eq("cmd_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("cmd_rw", rw, e.rw);
                check_eq("cmd_addr", addr, e.addr);
                if (!e.rw) check_eq("cmd_wdata", data_f2s, e.data);
            end
        end
    end

    task automatic push_run(input logic [1:0] sel, input int n_w, input bit reads);
        for (int a = 0; a < n_w; a++) exp_q.push_back({1'b0, ADDR_W'(a), exp_pat(a, sel)});
        if (reads) begin
            for (int a = 0; a < 16; a++) exp_q.push_back({1'b1, ADDR_W'(a), 8'h00});
        end
    endtask

    task automatic wait_done(input bit drop, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
            if (drop) start = 1'b0;
        end while (!done && cycles < 1000);
        check_eq("done_seen", done, 1'b1);
    endtask

    task automatic do_run(input logic [1:0] sel, input bit hold, output int cycles);
        @(negedge clk);
        pattern_sel = sel;
        start       = 1'b1;
        wait_done(!hold, cycles);
    endtask

    initial begin
        int cyc;
        int base;
        reset_n     = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        pattern_sel = 2'd0;
        for (int i = 0; i < 16; i++) sram[i] = 8'h00;
        repeat (3) @(negedge clk);

        check_eq("rst_mem", mem, 1'b0);
        check_eq("rst_rw", rw, 1'b0);
        check_eq("rst_addr", addr, 0);
        check_eq("rst_wdata", data_f2s, 0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_pass", pass, 1'b0);
        check_eq("rst_err", err_count, 0);
        check_eq("rst_ferr_addr", first_err_addr, 0);

        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("no_cmd_before_start", cmd_count, 0);
        check_eq("idle_busy", busy, 1'b0);

        // Fault-free address pattern
        fault_mode = 0;
        push_run(2'd0, 16, 1'b1);
        do_run(2'd0, 1'b0, cyc);
        check_eq("r1_cycles", cyc, 129);
        check_eq("r1_pass", pass, 1'b1);
        check_eq("r1_err", err_count, 0);
        check_eq("r1_busy", busy, 1'b0);
        check_eq("r1_sb_empty", exp_q.size(), 0);

        // Single stuck bit at address 5
        fault_mode = 1;
        push_run(2'd0, 16, 1'b1);
        do_run(2'd0, 1'b0, cyc);
        check_eq("r2_err", err_count, 1);
        check_eq("r2_ferr_addr", first_err_addr, 5);
        check_eq("r2_ferr_exp", first_err_exp, 8'h05);
        check_eq("r2_ferr_act", first_err_act, 8'h04);
        check_eq("r2_pass", pass, 1'b0);

        // 0xAA pattern against an all-zero read model
        fault_mode = 2;
        push_run(2'd3, 16, 1'b1);
        do_run(2'd3, 1'b0, cyc);
        check_eq("r3_err", err_count, 16);
        check_eq("r3_ferr_addr", first_err_addr, 0);
        check_eq("r3_ferr_exp", first_err_exp, 8'hAA);
        check_eq("r3_ferr_act", first_err_act, 8'h00);
        check_eq("r3_pass", pass, 1'b0);

        // start held high: no restart while busy, restart from DONE clears results
        fault_mode = 0;
        push_run(2'd2, 16, 1'b1);
        do_run(2'd2, 1'b1, cyc);
        check_eq("r4_cycles", cyc, 129);
        check_eq("r4_err_cleared", err_count, 0);
        check_eq("r4_ferr_exp_cleared", first_err_exp, 0);
        check_eq("r4_pass", pass, 1'b1);
        check_eq("r4_sb_empty", exp_q.size(), 0);
        push_run(2'd2, 16, 1'b1);
        @(posedge clk);
        #1;
        check_eq("r4_restart_busy", busy, 1'b1);
        check_eq("r4_restart_done", done, 1'b0);
        wait_done(1'b1, cyc);
        check_eq("r5_cycles", cyc, 128);
        check_eq("r5_pass", pass, 1'b1);
        check_eq("r5_sb_empty", exp_q.size(), 0);

        // Abort during the write of address 7
        base = cmd_count;
        push_run(2'd0, 8, 1'b0);
        @(negedge clk);
        pattern_sel = 2'd0;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 500 && cmd_count < base + 8; n++) @(negedge clk);
        check_eq("ab_reached_a7", cmd_count - base, 8);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int n = 0; n < 20 && busy; n++) @(negedge clk);
        check_eq("ab_busy", busy, 1'b0);
        check_eq("ab_done", done, 1'b0);
        check_eq("ab_a7_written", sram[7], 8'h07);
        check_eq("ab_a8_untouched", sram[8], 8'h55);
        repeat (20) @(negedge clk);
        check_eq("ab_no_more_cmds", cmd_count - base, 8);
        check_eq("ab_sb_empty", exp_q.size(), 0);

        // Asynchronous reset in the middle of a write
        base = cmd_count;
        push_run(2'd1, 16, 1'b1);
        @(negedge clk);
        pattern_sel = 2'd1;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 500 && !(mem && !rw && cmd_count >= base + 3); n++) @(negedge clk);
        check_eq("rs_mid_write", mem, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rs_mem", mem, 1'b0);
        check_eq("rs_busy", busy, 1'b0);
        check_eq("rs_done", done, 1'b0);
        check_eq("rs_err", err_count, 0);
        check_eq("rs_wdata", data_f2s, 0);
        exp_q.delete();
        base = cmd_count;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("rs_no_cmd_after", cmd_count - base, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
